// File: rtl/seven_segment_reader_pkg.sv
// Shared seven-segment definitions used by the display encoder and the reader.
//   SEG_CODE  : active-low a..g patterns (bit0=a .. bit6=g) for hex 0..F
//   SEG_BLANK : all segments off
//   seg_encode: value -> pattern helper
//   reader_state_t : frame assembly states of the reader
package seven_segment_reader_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } reader_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    return SEG_CODE[value];
  endfunction

endpackage

// File: rtl/seven_segment_reader_pattern_decode.sv
// Combinational seven-segment pattern decoder.
//   pattern : active-low segment pattern (bit0=a .. bit6=g)
//   value   : decoded hex value, 0 when blank or bad
//   blank   : pattern is all segments off
//   bad     : pattern is neither a table entry nor blank
module seven_segment_pattern_decode
  import seven_segment_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       blank,
  output logic       bad
);

  logic hit;

  always_comb begin
    value = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        value = i[3:0];
        hit   = 1'b1;
      end
    end
    blank = (pattern == SEG_BLANK);
    bad   = !hit && !blank;
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed seven-segment display and assembles whole frames.
//   clk, reset_n   : system clock, asynchronous active-low reset
//   segments       : active-low segment lines, asynchronous to clk
//   anodes         : active-low one-hot digit select, asynchronous to clk
//   frame_digits   : decoded values, digit i at [4i+3:4i]
//   frame_blank    : per-digit blank flags
//   frame_bad      : per-digit undecodable flags
//   frame_valid    : frame held for the consumer
//   frame_ready    : consumer accepts the held frame
module seven_segment_reader
  import seven_segment_reader_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            segments,
  input  logic [DIGITS-1:0]     anodes,
  output logic [4*DIGITS-1:0]   frame_digits,
  output logic [DIGITS-1:0]     frame_blank,
  output logic [DIGITS-1:0]     frame_bad,
  output logic                  frame_valid,
  input  logic                  frame_ready
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  logic [6:0]          seg_s1, seg_s2, seg_p;
  logic [DIGITS-1:0]   an_s1, an_s2, an_p;
  logic [7:0]          stable_cnt;
  logic                same, capture;
  logic [DIGITS-1:0]   cap_mask;

  logic [3:0]          dec_value;
  logic                dec_blank, dec_bad;

  logic [4*DIGITS-1:0] wk_digits, nx_digits;
  logic [DIGITS-1:0]   wk_blank, nx_blank, wk_bad, nx_bad;
  logic [DIGITS-1:0]   seen, seen_nx;

  reader_state_t       state, state_nx;
  logic                frame_done, frame_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      seg_p  <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
      an_p   <= '0;
    end else begin
      seg_s1 <= segments;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      an_s1  <= anodes;
      an_s2  <= an_s1;
      an_p   <= an_s2;
    end
  end

  assign same = (seg_s2 == seg_p) && (an_s2 == an_p);

  // stable_cnt holds the number of cycles the current s2 value has been
  // present so far, excluding this cycle; capture fires on the one cycle
  // the count would step to STABLE_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stable_cnt <= '0;
    else if (!same)
      stable_cnt <= 8'd1;
    else if (stable_cnt != CNT_MAX)
      stable_cnt <= stable_cnt + 8'd1;
  end

  assign capture  = same && (stable_cnt == CNT_CAP) && $onehot(~an_s2);
  assign cap_mask = capture ? ~an_s2 : '0;

  seven_segment_pattern_decode u_decode (
    .pattern (seg_s2),
    .value   (dec_value),
    .blank   (dec_blank),
    .bad     (dec_bad)
  );

  // Working slots including this cycle's capture, so a completing frame
  // carries the digit captured on the completion cycle.
  always_comb begin
    nx_digits = wk_digits;
    nx_blank  = wk_blank;
    nx_bad    = wk_bad;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cap_mask[i]) begin
        nx_digits[4*i +: 4] = dec_value;
        nx_blank[i]         = dec_blank;
        nx_bad[i]           = dec_bad;
      end
    end
    seen_nx = seen | cap_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= COLLECT;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    frame_done  = 1'b0;
    frame_taken = 1'b0;
    case (state)
      COLLECT: begin
        if (&seen_nx) begin
          frame_done = 1'b1;
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (frame_valid && frame_ready) begin
          frame_taken = 1'b1;
          state_nx    = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wk_digits    <= '0;
      wk_blank     <= '0;
      wk_bad       <= '0;
      seen         <= '0;
      frame_digits <= '0;
      frame_blank  <= '0;
      frame_bad    <= '0;
      frame_valid  <= 1'b0;
    end else begin
      wk_digits <= nx_digits;
      wk_blank  <= nx_blank;
      wk_bad    <= nx_bad;
      seen      <= frame_done ? '0 : seen_nx;
      if (frame_done) begin
        frame_digits <= nx_digits;
        frame_blank  <= nx_blank;
        frame_bad    <= nx_bad;
        frame_valid  <= 1'b1;
      end else if (frame_taken) begin
        frame_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboarded bench for seven_segment_reader with an event-level model.
module tb_seven_segment_reader;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic [15:0] frame_digits;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_bad;
  logic        frame_valid;
  logic        frame_ready;

  always #5 clk = ~clk;

  seven_segment_reader #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .segments     (segments),
    .anodes       (anodes),
    .frame_digits (frame_digits),
    .frame_blank  (frame_blank),
    .frame_bad    (frame_bad),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  bad;
  } frame_t;

  frame_t exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] ref_code [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // model of the working frame
  logic [3:0] m_val [4];
  logic [3:0] m_blank, m_bad, m_seen;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  function automatic void ref_decode(input logic [6:0] seg, output logic [3:0] v,
                                     output logic bl, output logic bd);
    v  = 4'h0;
    bl = (seg == 7'h7F);
    bd = !bl;
    for (int k = 0; k < 16; k++)
      if (seg == ref_code[k]) begin
        v  = k[3:0];
        bd = 1'b0;
      end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
    m_blank = '0;
    m_bad   = '0;
    m_seen  = '0;
  endfunction

  // One displayed pattern held for 'hold' cycles; consumer always ready.
  function automatic void model_apply(input logic [3:0] an, input logic [6:0] seg, input int hold);
    logic [3:0] v;
    logic bl, bd;
    int idx;
    frame_t f;
    if (hold >= int'(STABLE) && $countones(~an) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
      ref_decode(seg, v, bl, bd);
      m_val[idx]   = v;
      m_blank[idx] = bl;
      m_bad[idx]   = bd;
      m_seen[idx]  = 1'b1;
      if (&m_seen) begin
        for (int i = 0; i < 4; i++) f.digits[4*i +: 4] = m_val[i];
        f.blank = m_blank;
        f.bad   = m_bad;
        exp_q.push_back(f);
        m_seen = '0;
      end
    end
  endfunction

  function automatic void push_exp(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bd);
    frame_t f;
    f.digits = d;
    f.blank  = bl;
    f.bad    = bd;
    exp_q.push_back(f);
  endfunction

  // monitor: every new frame presented is compared against the queue head
  logic last_valid = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    if (!reset_n) begin
      last_valid = 1'b0;
    end else begin
      if (frame_valid && !last_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: actual digits=%h blank=%b bad=%b, required no frame",
                   frame_digits, frame_blank, frame_bad);
        end else begin
          f = exp_q.pop_front();
          check("frame_digits", 32'(frame_digits), 32'(f.digits));
          check("frame_blank",  32'(frame_blank),  32'(f.blank));
          check("frame_bad",    32'(frame_bad),    32'(f.bad));
        end
      end
      last_valid = frame_valid;
    end
  end

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int cyc);
    anodes   = an;
    segments = seg;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic show_digit(input int d, input logic [3:0] val, input int cyc);
    show(~(4'b0001 << d), ref_code[val], cyc);
  endtask

  task automatic idle(input int cyc);
    show(4'hF, 7'h7F, cyc);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_valid",  32'(frame_valid),  32'h0);
    check("reset_digits", 32'(frame_digits), 32'h0);
    check("reset_blank",  32'(frame_blank),  32'h0);
    check("reset_bad",    32'(frame_bad),    32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input string name, input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      @(posedge clk);
      #1;
      b++;
    end
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int b = 0;
    while (!frame_valid && b < budget) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("wait_valid", 32'(frame_valid), 32'h1);
  endtask

  initial begin
    logic [3:0] an, pan;
    logic [6:0] seg, pseg;
    int hold, sel, d;

    reset_n     = 1'b0;
    frame_ready = 1'b1;
    anodes      = 4'hF;
    segments    = 7'h7F;
    #1;
    do_reset();
    idle(3);

    // randomized scan, consumer always ready
    pan  = 4'hF;
    pseg = 7'h7F;
    for (int e = 0; e < 300; e++) begin
      do begin
        sel = $urandom_range(0, 99);
        if (sel < 85) an = ~(4'b0001 << $urandom_range(0, 3));
        else          an = 4'($urandom_range(0, 15));
        sel = $urandom_range(0, 99);
        if (sel < 70)      seg = ref_code[$urandom_range(0, 15)];
        else if (sel < 80) seg = 7'h7F;
        else               seg = 7'($urandom_range(0, 127));
      end while (an == pan && seg == pseg);
      hold = $urandom_range(1, 8);
      model_apply(an, seg, hold);
      show(an, seg, hold);
      pan  = an;
      pseg = seg;
    end
    idle(10);
    drain("random_drain", 200);

    // basic scan 1,2,3,4
    do_reset();
    idle(2);
    push_exp(16'h4321, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) show_digit(i, 4'(i + 1), 8);
    idle(4);
    drain("scan_drain", 50);

    // blank and undecodable codes
    do_reset();
    idle(2);
    push_exp(16'hFA00, 4'b0001, 4'b0010);
    show(4'hE, 7'h7F, 8);
    show(4'hD, 7'h55, 8);
    show_digit(2, 4'hA, 8);
    show_digit(3, 4'hF, 8);
    idle(4);
    drain("codes_drain", 50);

    // short glitch and invalid anode patterns never capture
    do_reset();
    idle(2);
    push_exp(16'h9652, 4'h0, 4'h0);
    show_digit(0, 4'h2, 8);
    show_digit(1, 4'h5, 8);
    show_digit(2, 4'h6, 8);
    show_digit(3, 4'hC, STABLE - 1);
    show(4'hC, ref_code[1], 12);
    show(4'hF, ref_code[1], 12);
    idle(12);
    @(negedge clk);
    check("no_early_frame", 32'(frame_valid), 32'h0);
    @(posedge clk);
    #1;
    show_digit(3, 4'h9, 8);
    idle(4);
    drain("glitch_drain", 50);

    // backpressure: held frame survives a changing scan
    do_reset();
    frame_ready = 1'b0;
    idle(2);
    push_exp(16'h4321, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) show_digit(i, 4'(i + 1), 8);
    wait_valid(50);
    for (int c = 0; c < 100; c++) begin
      d = (c / 8) % 4;
      anodes   = ~(4'b0001 << d);
      segments = ref_code[4'(d + 5)];
      @(negedge clk);
      check("hold_digits", 32'(frame_digits), 32'h4321);
      check("hold_valid",  32'(frame_valid),  32'h1);
      @(posedge clk);
      #1;
    end
    push_exp(16'h8765, 4'h0, 4'h0);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    drain("backpressure_drain", 20);
    @(negedge clk);
    check("held_valid", 32'(frame_valid), 32'h1);
    @(posedge clk);
    #1;

    // reset while a frame is held
    do_reset();
    frame_ready = 1'b1;
    idle(20);
    push_exp(16'hCBA9, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) show_digit(i, 4'(i + 9), 8);
    idle(4);
    drain("post_reset_drain", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (2..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical samples required before capture (2..255).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port segments, input, 7, active-low segment lines: bit0=a through bit6=g; asynchronous to clk.
REQ-006 SHALL have port anodes, input, DIGITS, active-low one-hot digit select; asynchronous to clk.
REQ-007 SHALL have port frame_digits, output, 4*DIGITS, decoded hex values; digit i at bits [4i+3:4i].
REQ-008 SHALL have port frame_blank, output, DIGITS, per-digit flag: pattern 7'h7F (all off).
REQ-009 SHALL have port frame_bad, output, DIGITS, per-digit flag: pattern not in decode table and not blank.
REQ-010 SHALL have port frame_valid, output, 1, frame held for consumer.
REQ-011 SHALL have port frame_ready, input, 1, consumer accepts frame.

Function
REQ-012 SHALL pass segments and anodes through a two-flop synchronizer; later logic uses only the second-stage value (s2).
REQ-013 SHALL count consecutive cycles in which s2 equals its previous-cycle value; the count resets to 1 on any change and saturates at STABLE_CYCLES.
REQ-014 SHALL capture exactly once per stable period, on the cycle the count first reaches STABLE_CYCLES, and only if s2 anodes has exactly one bit low.
REQ-015 SHALL ignore stable periods with zero or multiple anodes low (no capture, no flag).
REQ-016 SHALL decode segment hex patterns: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-017 SHALL store, on capture, value (0 if blank or bad), blank and bad flags into working slot i for the selected digit i, and set seen[i].
REQ-018 SHALL use two FSM states, COLLECT and HOLD.
REQ-019 In COLLECT, the block SHALL transition to HOLD when all seen bits are set. The transition cycle SHALL copy the working slots to the frame outputs, set frame_valid next cycle, and clear seen.
REQ-020 In HOLD, frame outputs SHALL stay constant. Captures SHALL continue updating working slots and seen.
REQ-021 In HOLD, frame_valid and frame_ready both high SHALL return the FSM to COLLECT with frame_valid low next cycle.
REQ-022 frame_ready SHALL be ignored while frame_valid is low, including on the completion cycle.
REQ-023 If all seen bits are already set on return to COLLECT, the next frame SHALL complete on the following cycle.
REQ-024 A capture and frame completion in the same cycle SHALL include the newly captured slot in the frame.

Reset
REQ-025 reset_n low SHALL asynchronously clear synchronizers, stable count, working slots, seen, FSM (to COLLECT), frame_digits, frame_blank, frame_bad and frame_valid to 0.
REQ-026 Assertion mid-frame or in HOLD SHALL discard all partial and pending data; deassertion SHALL require a fresh STABLE_CYCLES period before any capture.

Structure
REQ-027 The 16-entry segment code table and the blank code 7'h7F SHALL reside in a shared package used by both display encoder and reader.
REQ-028 Pattern decode (7-bit to value/blank/bad) SHALL be a combinational sub-module named seven_segment_pattern_decode.

Verification
REQ-029 Scan: DIGITS=4, scan 4 digits showing 1,2,3,4 (anodes E,D,B,7; segments 79,24,30,19), 8 cycles each -> frame_valid=1, frame_digits=16'h4321, blank/bad=0.
REQ-030 Glitch: a pattern held for STABLE_CYCLES-1 cycles, then changed -> no capture; seen unchanged.
REQ-031 Codes: segments 7F on digit 0 -> blank[0]=1; segments 55 on digit 1 -> bad[1]=1, value 0.
REQ-032 Backpressure: frame_ready=0 for 100 cycles while the scan changes to 5,6,7,8 -> frame outputs stay 16'h4321. Then ready=1 for one cycle -> the next frame reports 16'h8765.
REQ-033 Invalid anodes: anodes=4'hC or 4'hF, stable -> no capture.
REQ-034 Reset in HOLD: reset_n low for 1 cycle -> all outputs 0; the following scan produces a fresh full frame.
